servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_pkg.sv | 25 ++
 rtl/servo_pwm_timebase.sv | 44 ++++
 rtl/servo_pwm_multi.sv | 106 ++++++++++
 tb/tb_servo_pwm_multi.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared defaults and helpers for the multi-channel servo PWM generator.
// Every servo_pwm_* file imports this package.
package servo_pwm_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_TICK_DIV  = 100;
  localparam int DEF_PERIOD_US = 20000;
  localparam int DEF_MIN_US    = 1000;
  localparam int DEF_MAX_US    = 2000;
  localparam int DEF_PW_W      = 16;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W = ch_idx_w(DEF_NUM_CH);

  function automatic int clamp_pw(input int pw, input int lo, input int hi);
    if (pw < lo) return lo;
    if (pw > hi) return hi;
    return pw;
  endfunction

endpackage

// File: rtl/servo_pwm_timebase.sv
// Shared microsecond prescaler and frame counter.
// frame_start marks the first clk of every frame.
module servo_pwm_timebase
  import servo_pwm_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int PW_W      = DEF_PW_W
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tick,
  output logic [PW_W-1:0] frame_cnt,
  output logic            frame_start
);

  localparam int PS_W = $clog2(TICK_DIV);

  logic [PS_W-1:0] r_presc;
  logic [PW_W-1:0] r_frameCnt;
  logic            r_frameStart;
  logic            w_wrap;

  assign tick        = (r_presc == PS_W'(TICK_DIV - 1));
  assign w_wrap      = tick && (r_frameCnt == PW_W'(PERIOD_US - 1));
  assign frame_cnt   = r_frameCnt;
  assign frame_start = r_frameStart;

  // The strobe is registered so that it lines up with the cycle where the counter reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_frameCnt   <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_presc      <= tick ? '0 : r_presc + PS_W'(1);
      r_frameStart <= w_wrap;
      if (tick) begin
        r_frameCnt <= w_wrap ? '0 : r_frameCnt + PW_W'(1);
      end
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator with frame-synchronous width/enable updates.
// Pad-ready outputs: pwm_out is the data level and pwm_t is the tristate control.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int MIN_US    = DEF_MIN_US,
  parameter int MAX_US    = DEF_MAX_US,
  parameter int PW_W      = DEF_PW_W,
  localparam int CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [PW_W-1:0]   wr_pw,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_t,
  output logic              frame_start
);

  localparam int MID_US = (MIN_US + MAX_US) / 2;

  if (!(NUM_CH >= 1 && NUM_CH <= 16 && TICK_DIV >= 2 && MIN_US >= 0 &&
        MIN_US <= MAX_US && MAX_US < PERIOD_US &&
        longint'(PERIOD_US) < (longint'(1) << PW_W))) begin : g_badParams
    $fatal(1, "servo_pwm_multi: illegal parameter combination");
  end

  logic            w_tick;
  logic            w_frameStart;
  logic [PW_W-1:0] w_frameCnt;
  logic [PW_W-1:0] w_clampedPw;
  logic            w_outEn;
  logic            r_tickD;

  servo_pwm_timebase #(
    .TICK_DIV  (TICK_DIV),
    .PERIOD_US (PERIOD_US),
    .PW_W      (PW_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .tick        (w_tick),
    .frame_cnt   (w_frameCnt),
    .frame_start (w_frameStart)
  );

  assign wr_ready    = ~rst;
  assign frame_start = w_frameStart;
  assign w_clampedPw = PW_W'(clamp_pw(int'(wr_pw), MIN_US, MAX_US));
  // Comparator inputs only move after a tick or at a boundary, so the output flops idle otherwise.
  assign w_outEn     = r_tickD | w_frameStart;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tickD <= 1'b0;
    end else begin
      r_tickD <= w_tick;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PW_W-1:0] r_pend;
    logic [PW_W-1:0] r_act;
    logic            r_actEn;
    logic            r_pwmOut;
    logic            r_pwmT;
    logic [PW_W-1:0] w_effW;
    logic            w_effEn;

    // In the boundary cycle the new frame already uses the pending values; later writes wait a frame.
    assign w_effW  = w_frameStart ? r_pend   : r_act;
    assign w_effEn = w_frameStart ? ch_en[i] : r_actEn;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pend   <= PW_W'(MID_US);
        r_act    <= PW_W'(MID_US);
        r_actEn  <= 1'b0;
        r_pwmOut <= 1'b0;
        r_pwmT   <= 1'b1;
      end else begin
        if (wr_valid && wr_ready && (wr_ch == CH_W'(i))) begin
          r_pend <= w_clampedPw;
        end
        if (w_frameStart) begin
          r_act   <= r_pend;
          r_actEn <= ch_en[i];
        end
        if (w_outEn) begin
          r_pwmOut <= w_effEn && (w_frameCnt < w_effW);
          r_pwmT   <= ~w_effEn;
        end
      end
    end

    assign pwm_out[i] = r_pwmOut;
    assign pwm_t[i]   = r_pwmT;
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench: frame-level reference model of pulse widths and enables,
// with directed scenarios followed by randomized writes and enable changes.
module tb_servo_pwm_multi;

  localparam int TD   = 2;
  localparam int PER  = 20;
  localparam int MINW = 2;
  localparam int MAXW = 10;
  localparam int MIDW = (MINW + MAXW) / 2;
  localparam int FRAME_CLK = TD * PER;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrValid;
  logic        wrValidB;
  logic [1:0]  wrCh;
  logic [15:0] wrPw;
  logic [3:0]  chEn;
  logic [2:0]  chEnB;
  logic        wrReady;
  logic        wrReadyB;
  logic [3:0]  pwmOut;
  logic [3:0]  pwmT;
  logic [2:0]  pwmOutB;
  logic [2:0]  pwmTB;
  logic        frameStart;
  logic        frameStartB;

  int total = 0;
  int bad   = 0;
  int mPend[4];
  int bPend[3];

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(4), .TICK_DIV(TD), .PERIOD_US(PER), .MIN_US(MINW), .MAX_US(MAXW), .PW_W(16)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wrValid), .wr_ready(wrReady), .wr_ch(wrCh),
    .wr_pw(wrPw), .ch_en(chEn), .pwm_out(pwmOut), .pwm_t(pwmT), .frame_start(frameStart)
  );

  // Three-channel copy: a two-bit index of 3 is out of range here.
  servo_pwm_multi #(
    .NUM_CH(3), .TICK_DIV(TD), .PERIOD_US(PER), .MIN_US(MINW), .MAX_US(MAXW), .PW_W(16)
  ) dutB (
    .clk(clk), .rst(rst), .wr_valid(wrValidB), .wr_ready(wrReadyB), .wr_ch(wrCh),
    .wr_pw(wrPw), .ch_en(chEnB), .pwm_out(pwmOutB), .pwm_t(pwmTB), .frame_start(frameStartB)
  );

  function automatic int clampRef(input int v);
    if (v < MINW) return MINW;
    if (v > MAXW) return MAXW;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mPend[c] = MIDW;
    for (int c = 0; c < 3; c++) bPend[c] = MIDW;
  endtask

  // After reset release: outputs stay idle and the first boundary comes FRAME_CLK edges later.
  task automatic test_first_frame();
    int firstFs = -1;
    int idleErr = 0;
    for (int k = 1; k <= FRAME_CLK + 20; k++) begin
      step();
      if (k <= FRAME_CLK && (pwmOut !== 4'h0 || pwmT !== 4'hF || pwmOutB !== 3'h0 || pwmTB !== 3'h7))
        idleErr++;
      if (frameStart === 1'b1) begin
        firstFs = k;
        break;
      end
    end
    total++;
    if (firstFs !== FRAME_CLK) begin
      bad++;
      $display("[TB] FAIL first_boundary: got cycle %0d want %0d", firstFs, FRAME_CLK);
    end
    total++;
    if (idleErr !== 0) begin
      bad++;
      $display("[TB] FAIL first_frame_idle: got %0d bad cycles want 0", idleErr);
    end
    total++;
    if (wrReady !== 1'b1 || frameStartB !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got ready=%b fsB=%b want 1 1", wrReady, frameStartB);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wrValid = 1'b0; wrValidB = 1'b0; wrCh = '0; wrPw = '0;
    chEn = 4'hF; chEnB = 3'h7;
    repeat (3) step();
    total++;
    if (pwmOut !== 4'h0 || pwmT !== 4'hF || pwmOutB !== 3'h0 || pwmTB !== 3'h7) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got out=%h t=%h want out=0 t=f", pwmOut, pwmT);
    end
    total++;
    if (frameStart !== 1'b0 || wrReady !== 1'b0 || wrReadyB !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_strobes: got fs=%b ready=%b want 0 0", frameStart, wrReady);
    end
    model_reset();
    rst = 1'b0;
    test_first_frame();
  endtask

  // Runs one frame from a boundary to the next, with an optional write and ch_en change.
  // wrSel: 0 none, 1 main DUT, 2 three-channel DUT.
  task automatic run_frame(input string tag, input int wrSel, input int wrOff, input int wrChan,
                           input int wrVal, input int enOff, input logic [3:0] enVal);
    int cnt[4];
    int cntB[3];
    int fW[4];
    int fWB[3];
    logic [3:0] fEn;
    logic [2:0] fEnB;
    logic [3:0] rise;
    int tErr = 0;
    int fsErr = 0;
    int expCnt;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int c = 0; c < 3; c++) cntB[c] = 0;
    rise = 'x;
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (i == enOff) chEn = enVal;
      if (i == 0) begin
        for (int c = 0; c < 4; c++) fW[c] = mPend[c];
        for (int c = 0; c < 3; c++) fWB[c] = bPend[c];
        fEn  = chEn;
        fEnB = chEnB;
      end
      if (wrSel != 0 && i == wrOff) begin
        wrCh = wrChan[1:0];
        wrPw = wrVal[15:0];
        if (wrSel == 1) begin
          wrValid = 1'b1;
          mPend[wrChan] = clampRef(wrVal);
        end else begin
          wrValidB = 1'b1;
          if (wrChan < 3) bPend[wrChan] = clampRef(wrVal);
        end
      end
      step();
      wrValid = 1'b0;
      wrValidB = 1'b0;
      if (i == 0) rise = pwmOut;
      for (int c = 0; c < 4; c++) if (pwmOut[c] === 1'b1) cnt[c]++;
      for (int c = 0; c < 3; c++) if (pwmOutB[c] === 1'b1) cntB[c]++;
      if (pwmT !== ~fEn || pwmTB !== ~fEnB || (pwmOut & pwmT) !== 4'h0 || (pwmOutB & pwmTB) !== 3'h0)
        tErr++;
      if (i < FRAME_CLK - 1 && (frameStart !== 1'b0 || frameStartB !== 1'b0)) fsErr++;
    end
    total++;
    if (frameStart !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s frame_start: got %b want 1", tag, frameStart);
    end
    total++;
    if (rise !== fEn) begin
      bad++;
      $display("[TB] FAIL %s rising_edges: got %h want %h", tag, rise, fEn);
    end
    for (int c = 0; c < 4; c++) begin
      expCnt = fEn[c] ? TD * fW[c] : 0;
      total++;
      if (cnt[c] !== expCnt) begin
        bad++;
        $display("[TB] FAIL %s high_clk ch%0d: got %0d want %0d", tag, c, cnt[c], expCnt);
      end
    end
    for (int c = 0; c < 3; c++) begin
      expCnt = fEnB[c] ? TD * fWB[c] : 0;
      total++;
      if (cntB[c] !== expCnt) begin
        bad++;
        $display("[TB] FAIL %s high_clk dutB ch%0d: got %0d want %0d", tag, c, cntB[c], expCnt);
      end
    end
    total++;
    if (tErr !== 0) begin
      bad++;
      $display("[TB] FAIL %s tristate: got %0d bad cycles want 0", tag, tErr);
    end
    total++;
    if (fsErr !== 0) begin
      bad++;
      $display("[TB] FAIL %s strobe_width: got %0d extra strobes want 0", tag, fsErr);
    end
  endtask

  task automatic test_static();
    run_frame("static0", 0, 0, 0, 0, -1, 4'h0);
    run_frame("static1", 0, 0, 0, 0, -1, 4'h0);
  endtask

  task automatic test_mid_write();
    run_frame("midwr", 1, 11, 1, 8, -1, 4'h0);
    run_frame("midwr_next", 0, 0, 0, 0, -1, 4'h0);
  endtask

  task automatic test_clamp();
    run_frame("clamp_lo_wr", 1, 5, 2, 0, -1, 4'h0);
    run_frame("clamp_hi_wr", 1, 7, 2, 15, -1, 4'h0);
    run_frame("clamp_hi", 0, 0, 0, 0, -1, 4'h0);
  endtask

  task automatic test_boundary_write();
    run_frame("bnd_wr", 1, 0, 3, 3, -1, 4'h0);
    run_frame("bnd_next", 0, 0, 0, 0, -1, 4'h0);
  endtask

  task automatic test_enable_drop();
    run_frame("en_drop", 0, 0, 0, 0, 3, 4'hE);
    run_frame("en_off", 0, 0, 0, 0, -1, 4'h0);
    run_frame("en_back", 0, 0, 0, 0, 0, 4'hF);
  endtask

  task automatic test_back_to_back();
    int sel, off, ch, val, eOff;
    logic [3:0] eVal;
    for (int f = 0; f < 10; f++) begin
      sel  = $urandom_range(0, 2);
      off  = $urandom_range(0, FRAME_CLK - 1);
      ch   = $urandom_range(0, 3);
      val  = $urandom_range(0, 31);
      eOff = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME_CLK - 1)) : -1;
      eVal = 4'($urandom_range(0, 15));
      run_frame("random", sel, off, ch, val, eOff, eVal);
    end
    run_frame("random_tail", 0, 0, 0, 0, 0, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic [3:0] act;
    act = chEn;
    repeat (3) step();
    total++;
    if (pwmOut !== act) begin
      bad++;
      $display("[TB] FAIL mid_pulse_level: got %h want %h", pwmOut, act);
    end
    rst = 1'b1;
    wrValid = 1'b1; wrCh = 2'd1; wrPw = 16'd9;
    step();
    total++;
    if (pwmOut !== 4'h0 || pwmT !== 4'hF || pwmOutB !== 3'h0 || pwmTB !== 3'h7) begin
      bad++;
      $display("[TB] FAIL reset_mid_idle: got out=%h t=%h want out=0 t=f", pwmOut, pwmT);
    end
    total++;
    if (wrReady !== 1'b0 || frameStart !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_strobes: got ready=%b fs=%b want 0 0", wrReady, frameStart);
    end
    repeat (2) step();
    wrValid = 1'b0;
    chEn = 4'hF;
    model_reset();
    rst = 1'b0;
    test_first_frame();
    run_frame("after_reset", 0, 0, 0, 0, -1, 4'h0);
  endtask

  task automatic test_out_of_range();
    run_frame("oor_wr", 2, 12, 3, 9, -1, 4'h0);
    run_frame("oor_next", 0, 0, 0, 0, -1, 4'h0);
    run_frame("inrange_wr", 2, 20, 0, 9, -1, 4'h0);
    run_frame("inrange_next", 0, 0, 0, 0, -1, 4'h0);
  endtask

  initial begin
    $display("[TB] servo_pwm_multi bench start");
    test_reset();
    test_static();
    test_mid_write();
    test_clamp();
    test_boundary_write();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
